// File: rtl/flt_add_top.sv
// flt_add_top: half-precision adder FSM that reads operands from and writes the result to the internal memory dm.
// Define FLT_ADD_SUB_EN for signed operation (magnitude subtract on differing signs); default adds magnitudes.
module flt_add_mem #(
    parameter int MEM_DEPTH = 256,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    logic [7:0] mem_core [MEM_DEPTH];
    always_ff @(posedge clk)
        if (we) mem_core[addr] <= wdata;
    assign rdata = mem_core[addr];
endmodule

module flt_add_top #(
    parameter int MEM_DEPTH = 256,
    parameter int OP1_ADDR = 8,
    parameter int OP2_ADDR = 10,
    parameter int RES_ADDR = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [AW-1:0] A_O1L = AW'(OP1_ADDR);
    localparam logic [AW-1:0] A_O1H = AW'(OP1_ADDR + 1);
    localparam logic [AW-1:0] A_O2L = AW'(OP2_ADDR);
    localparam logic [AW-1:0] A_O2H = AW'(OP2_ADDR + 1);
    localparam logic [AW-1:0] A_RL = AW'(RES_ADDR);
    localparam logic [AW-1:0] A_RH = AW'(RES_ADDR + 1);

    typedef enum logic [3:0] {IDLE, RD0, RD1, RD2, RD3, ALIGN, ADD, NORM, WRLO, WRHI, DONE} state_t;
    state_t state, state_n;

    logic          start_q, trig, we, swap, sgn, sub, norm_done;
    logic [AW-1:0] addr;
    logic [7:0]    wdata, rdata;
    logic [15:0]   op1, op2, res, res_w;
    logic [4:0]    e1, e2, ediff, emax;
    logic [10:0]   m1, m2, mb, ms, mn;
    logic [11:0]   sum;
    logic [5:0]    en;

    flt_add_mem #(.MEM_DEPTH(MEM_DEPTH), .AW(AW)) dm (
        .clk(clk), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata)
    );

    assign trig = start_q && !start;
    assign done = (state == DONE);
    assign e1 = op1[14:10];
    assign e2 = op2[14:10];
    assign m1 = {|e1, op1[9:0]};
    assign m2 = {|e2, op2[9:0]};
`ifdef FLT_ADD_SUB_EN
    // Larger magnitude leads so the subtract never goes negative
    assign swap = op2[14:0] > op1[14:0];
    assign norm_done = sum[11] || sum[10] || emax == 5'd0 || sum == 12'd0;
`else
    assign swap = e2 > e1;
    assign norm_done = 1'b1;
`endif
    assign ediff = swap ? e2 - e1 : e1 - e2;
    assign en = sum[11] ? {1'b0, emax} + 6'd1 : {1'b0, emax};
    assign mn = sum[11] ? sum[11:1] : sum[10:0];
`ifdef FLT_ADD_SUB_EN
    assign res_w = sum == 12'd0 ? 16'h0000 : en >= 6'd31 ? {sgn, 5'h1F, 10'h000} : {sgn, en[4:0], mn[9:0]};
`else
    assign res_w = en >= 6'd31 ? {sgn, 5'h1F, 10'h000} : {sgn, en[4:0], mn[9:0]};
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            start_q <= 1'b0;
        end else begin
            state <= state_n;
            start_q <= start;
        end

    always_comb begin
        state_n = state;
        we = 1'b0;
        addr = A_O1L;
        wdata = res[7:0];
        case (state)
            IDLE, DONE: state_n = trig ? RD0 : start ? IDLE : state;
            RD0: state_n = RD1;
            RD1: begin addr = A_O1H; state_n = RD2; end
            RD2: begin addr = A_O2L; state_n = RD3; end
            RD3: begin addr = A_O2H; state_n = ALIGN; end
            ALIGN: state_n = ADD;
            ADD: state_n = NORM;
            NORM: state_n = norm_done ? WRLO : NORM;
            WRLO: begin we = 1'b1; addr = A_RL; state_n = WRHI; end
            WRHI: begin we = 1'b1; addr = A_RH; wdata = res[15:8]; state_n = DONE; end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            op1 <= '0;
            op2 <= '0;
            mb <= '0;
            ms <= '0;
            emax <= '0;
            sgn <= 1'b0;
            sub <= 1'b0;
            sum <= '0;
            res <= '0;
        end else begin
            case (state)
                RD0: op1[7:0] <= rdata;
                RD1: op1[15:8] <= rdata;
                RD2: op2[7:0] <= rdata;
                RD3: op2[15:8] <= rdata;
                ALIGN: begin
                    mb <= swap ? m2 : m1;
                    ms <= (swap ? m1 : m2) >> ediff;
                    emax <= swap ? e2 : e1;
`ifdef FLT_ADD_SUB_EN
                    sgn <= swap ? op2[15] : op1[15];
                    sub <= op1[15] ^ op2[15];
`else
                    sgn <= op1[15];
                    sub <= 1'b0;
`endif
                end
                ADD: sum <= sub ? {1'b0, mb} - {1'b0, ms} : {1'b0, mb} + {1'b0, ms};
                NORM:
                    if (norm_done) res <= res_w;
                    else begin
                        sum <= sum << 1;
                        emax <= emax - 5'd1;
                    end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_flt_add_top.sv
// tb_flt_add_top: directed vectors with scoreboard queue; monitor checks memory result on each done rise.
module tb_flt_add_top;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic done;

    flt_add_top dut (.clk(clk), .reset(reset), .start(start), .done(done));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        int lat_min;
        int lat_max;
        int id;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int cyc = 0, trig_cyc = 0, vectors = 0, errs = 0, lat;
    logic done_q = 1'b0;
    logic [15:0] got, saved;

    localparam int NV = 10;
    logic [15:0] va [NV] = '{16'h1A04, 16'h4A10, 16'h4200, 16'h5200, 16'h7A00,
                             16'h3C00, 16'hC000, 16'h8000, 16'h3C00, 16'h3C00};
    logic [15:0] vb [NV] = '{16'h1A04, 16'h4204, 16'h5604, 16'h0204, 16'h7A00,
                             16'h3C00, 16'h3C00, 16'h3C00, 16'h0000, 16'hBC00};
`ifdef FLT_ADD_SUB_EN
    logic [15:0] ve [NV] = '{16'h1E04, 16'h4B91, 16'h5634, 16'h5200, 16'h7C00,
                             16'h4000, 16'hBC00, 16'h3C00, 16'h3C00, 16'h0000};
    localparam int LMAX = 22;
`else
    logic [15:0] ve [NV] = '{16'h1E04, 16'h4B91, 16'h5634, 16'h5200, 16'h7C00,
                             16'h4000, 16'hC200, 16'hBC00, 16'h3C00, 16'h4000};
    localparam int LMAX = 10;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done && !done_q) begin
            if (q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_done: done rose with no run pending");
            end else begin
                e = q.pop_front();
                got = {dut.dm.mem_core[13], dut.dm.mem_core[12]};
                lat = cyc - trig_cyc;
                vectors++;
                if (got !== e.res) begin
                    errs++;
                    $display("FAIL result v%0d: got %h expected %h", e.id, got, e.res);
                end
                vectors++;
                if (lat < e.lat_min || lat > e.lat_max) begin
                    errs++;
                    $display("FAIL latency v%0d: got %0d expected %0d..%0d", e.id, lat, e.lat_min, e.lat_max);
                end
            end
        end
        done_q <= done;
    end

    task automatic check(input logic [15:0] act, input logic [15:0] req, input string nm);
        vectors++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] b);
        dut.dm.mem_core[8] = a[7:0];
        dut.dm.mem_core[9] = a[15:8];
        dut.dm.mem_core[10] = b[7:0];
        dut.dm.mem_core[11] = b[15:8];
    endtask

    task automatic trigger();
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check(16'(done), 16'h0, "done_cleared_by_start");
        start = 1'b0;
        trig_cyc = cyc;
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r, input int id);
        load(a, b);
        q.push_back('{r, 10, LMAX, id});
        trigger();
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        if (!done) begin
            errs++;
            $display("FAIL timeout v%0d: done=%b expected 1", id, done);
        end
        repeat (3) @(negedge clk);
        check(16'(done), 16'h1, "done_hold");
    endtask

    initial begin
        dut.dm.mem_core[7] = 8'h5A;
        dut.dm.mem_core[14] = 8'hA5;
        repeat (2) @(negedge clk);
        check(16'(done), 16'h0, "reset_done");
        reset = 1'b0;
        for (int i = 0; i < NV; i++) run(va[i], vb[i], ve[i], i);

        dut.dm.mem_core[12] = 8'hAA;
        dut.dm.mem_core[13] = 8'h55;
        saved = 16'h55AA;
        load(16'h3C00, 16'h3C00);
        trigger();
        repeat (5) @(negedge clk);
        check(16'(int'(dut.state)), 16'd5, "reached_align");
        reset = 1'b1;
        #1;
        check(16'(done), 16'h0, "abort_done");
        check(16'(int'(dut.state)), 16'd0, "abort_idle");
        @(negedge clk) reset = 1'b0;
        repeat (15) @(negedge clk);
        check(16'(done), 16'h0, "abort_no_done");
        check({dut.dm.mem_core[13], dut.dm.mem_core[12]}, saved, "abort_mem");
        run(16'h3C00, 16'h3C00, 16'h4000, 99);

        check({8'h00, dut.dm.mem_core[7]}, 16'h005A, "untouched_7");
        check({8'h00, dut.dm.mem_core[14]}, 16'h00A5, "untouched_14");
        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            errs++;
            $display("FAIL pending: got %0d outstanding expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
